// File: rtl/stopwatch_counter_if.sv
// Stopwatch control/display bundle: timer tick and buttons in, BCD digits and
// status flags out. The counter is the slave; the surrounding logic is the master.
interface stopwatch_counter_if;
    logic       second_tick;
    logic       start_stop;
    logic       clear;
    logic       timer_enable;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       rollover;
    logic       overflow;

    modport master (
        output second_tick, start_stop, clear,
        input  timer_enable, sec_ones, sec_tens, min_ones, min_tens, rollover, overflow
    );

    modport slave (
        input  second_tick, start_stop, clear,
        output timer_enable, sec_ones, sec_tens, min_ones, min_tens, rollover, overflow
    );
endinterface

// File: rtl/stopwatch_counter.sv
// Stopwatch counter: counts second_tick pulses as MM:SS in BCD, owns the
// start/stop/clear FSM and drives the upstream timer's enable.
module stopwatch_counter #(
    parameter int MAX_MINUTES = 59,
    parameter bit WRAP        = 1'b1
) (
    input  logic               clk,
    input  logic               n_rst,
    stopwatch_counter_if.slave sw
);

    localparam logic [3:0] MAX_TENS = 4'(MAX_MINUTES / 10);
    localparam logic [3:0] MAX_ONES = 4'(MAX_MINUTES % 10);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        start_stop_q;
    logic        press;
    logic        tick_cnt;
    logic        at_max;
    logic        timer_enable_p0;
    logic        rollover_p0;
    logic        overflow_p0;
    logic [15:0] digits_p0;   // {min_tens, min_ones, sec_tens, sec_ones}

    // One BCD step of the MM:SS count; at the last displayable value either
    // wraps to 00:00 or saturates, depending on WRAP.
    function automatic logic [15:0] bcd_next(input logic [15:0] cur, input logic max_hit);
        logic [3:0] so, st, mo, mt;
        {mt, mo, st, so} = cur;
        if (max_hit) begin
            bcd_next = WRAP ? 16'h0000 : cur;
        end else begin
            if (so != 4'd9) begin
                so = so + 4'd1;
            end else begin
                so = 4'd0;
                if (st != 4'd5) begin
                    st = st + 4'd1;
                end else begin
                    st = 4'd0;
                    if (mo != 4'd9) begin
                        mo = mo + 4'd1;
                    end else begin
                        mo = 4'd0;
                        mt = mt + 4'd1;
                    end
                end
            end
            bcd_next = {mt, mo, st, so};
        end
    endfunction

    assign press    = sw.start_stop & ~start_stop_q;
    assign tick_cnt = sw.second_tick & (state == RUNNING) & ~sw.clear;
    assign at_max   = (digits_p0[15:12] == MAX_TENS) && (digits_p0[11:8] == MAX_ONES) &&
                      (digits_p0[7:4] == 4'd5) && (digits_p0[3:0] == 4'd9);

    // Button edge detector: a held level produces a single press.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            start_stop_q <= 1'b0;
        end else begin
            start_stop_q <= sw.start_stop;
        end
    end

    // Next-state logic; clear overrides every other event.
    always_comb begin
        state_next = state;
        if (sw.clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (press) state_next = RUNNING;
                RUNNING: begin
                    if (press) begin
                        state_next = PAUSED;
                    end else if (tick_cnt && at_max && !WRAP) begin
                        state_next = PAUSED;
                    end
                end
                PAUSED:  if (press) state_next = RUNNING;
                default: state_next = IDLE;
            endcase
        end
    end

    // State register; timer_enable is registered alongside so it tracks RUNNING exactly.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state           <= IDLE;
            timer_enable_p0 <= 1'b0;
        end else begin
            state           <= state_next;
            timer_enable_p0 <= (state_next == RUNNING);
        end
    end

    // Digit counter with rollover pulse and sticky overflow flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            digits_p0   <= 16'h0000;
            rollover_p0 <= 1'b0;
            overflow_p0 <= 1'b0;
        end else if (sw.clear) begin
            digits_p0   <= 16'h0000;
            rollover_p0 <= 1'b0;
            overflow_p0 <= 1'b0;
        end else if (tick_cnt) begin
            digits_p0   <= bcd_next(digits_p0, at_max);
            rollover_p0 <= at_max;
            if (at_max) begin
                overflow_p0 <= 1'b1;
            end
        end else begin
            rollover_p0 <= 1'b0;
        end
    end

    assign sw.timer_enable = timer_enable_p0;
    assign sw.min_tens     = digits_p0[15:12];
    assign sw.min_ones     = digits_p0[11:8];
    assign sw.sec_tens     = digits_p0[7:4];
    assign sw.sec_ones     = digits_p0[3:0];
    assign sw.rollover     = rollover_p0;
    assign sw.overflow     = overflow_p0;

endmodule
